// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: boot loader writes the program image, then the PC
// streams one instruction per cycle from a synchronous-read memory.
module ifetch_unit #(
   parameter int unsigned           DATA_WIDTH  = 32,
   parameter int unsigned           ADDR_WIDTH  = 32,
   parameter int unsigned           DEPTH_WORDS = 1024,
   parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR   = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_valid,
   output logic                  load_ready,
   input  logic [ADDR_WIDTH-1:0] load_addr,
   input  logic [DATA_WIDTH-1:0] load_data,
   input  logic                  load_last,
   output logic                  load_err,
   input  logic                  stall,
   input  logic                  redirect,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic [DATA_WIDTH-1:0] instr,
   output logic [ADDR_WIDTH-1:0] instr_pc,
   output logic                  instr_valid,
   output logic                  running,
   output logic                  fault,
   output logic [ADDR_WIDTH-1:0] fault_pc
);

   localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   localparam logic [1:0] ST_LOAD  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_FAULT = 2'd2;

   logic [1:0]            state;
   logic [ADDR_WIDTH-1:0] fetch_pc;
   logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

   logic [ADDR_WIDTH-1:0] ld_word;
   logic [ADDR_WIDTH-1:0] rd_word;
   logic [ADDR_WIDTH-1:0] pc_word;
   logic                  ld_ok;
   logic                  rd_ok;
   logic                  pc_ok;
   logic                  wr_en;

   // Word index relative to BOOT_ADDR; in range when no bits remain above the index width.
   always_comb begin
      ld_word = (load_addr - BOOT_ADDR) >> 2;
      rd_word = (redirect_pc - BOOT_ADDR) >> 2;
      pc_word = (fetch_pc - BOOT_ADDR) >> 2;
      ld_ok   = (load_addr >= BOOT_ADDR) && ((ld_word >> IDX_W) == '0)
                && (load_addr[1:0] == 2'b00);
      rd_ok   = (redirect_pc >= BOOT_ADDR) && ((rd_word >> IDX_W) == '0)
                && (redirect_pc[1:0] == 2'b00);
      pc_ok   = (fetch_pc >= BOOT_ADDR) && ((pc_word >> IDX_W) == '0)
                && (fetch_pc[1:0] == 2'b00);
   end

   assign wr_en      = (state == ST_LOAD) && load_valid && ld_ok && !rst;
   assign load_ready = (state == ST_LOAD);
   assign running    = (state == ST_RUN);
   assign fault      = (state == ST_FAULT);

   // Memory contents survive reset so a previous image can be re-run.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[ld_word[IDX_W-1:0]] <= load_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_LOAD;
         fetch_pc    <= BOOT_ADDR;
         instr       <= '0;
         instr_pc    <= '0;
         instr_valid <= 1'b0;
         fault_pc    <= '0;
         load_err    <= 1'b0;
      end else begin
         case (state)
            ST_LOAD: begin
               fetch_pc    <= BOOT_ADDR;
               instr_valid <= 1'b0;
               if (load_valid) begin
                  if (!ld_ok) begin
                     load_err <= 1'b1;
                  end
                  if (load_last) begin
                     state <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               if (redirect && !rd_ok) begin
                  state       <= ST_FAULT;
                  fault_pc    <= redirect_pc;
                  instr_valid <= 1'b0;
               end else if (redirect) begin
                  // Squashes the in-flight fetch even when stalled.
                  fetch_pc    <= redirect_pc;
                  instr_valid <= 1'b0;
               end else if (!stall) begin
                  if (!pc_ok) begin
                     state       <= ST_FAULT;
                     fault_pc    <= fetch_pc;
                     instr_valid <= 1'b0;
                  end else begin
                     instr       <= mem[pc_word[IDX_W-1:0]];
                     instr_pc    <= fetch_pc;
                     instr_valid <= 1'b1;
                     fetch_pc    <= fetch_pc + ADDR_WIDTH'(4);
                  end
               end
            end
            default: begin
               instr_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Parametrised instruction-fetch stage: a program counter, a synchronous-read instruction memory and a boot-time program loader combined into one block. After reset it accepts a program image over a valid/ready write stream. On the last word it starts fetching sequentially from `BOOT_ADDR` and delivers one instruction per cycle with a valid flag, honouring stall and redirect (jump/branch) requests from the core. Misaligned or out-of-range fetches trap into a sticky fault state.

## Interface
- `DATA_WIDTH`, 32, instruction/data word width.
- `ADDR_WIDTH`, 32, byte-address width of PC, load and redirect addresses.
- `DEPTH_WORDS`, 1024, memory depth in words; power of two.
- `BOOT_ADDR`, 32'h0, byte address of word 0; word-aligned.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `load_valid`  in  1  loader word present.
- `load_ready`  out  1  block accepts loader words.
- `load_addr`  in  ADDR_WIDTH  byte address of loader word.
- `load_data`  in  DATA_WIDTH  loader word.
- `load_last`  in  1  accepted word is the final one of the image.
- `load_err`  out  1  sticky: an out-of-range or misaligned load was dropped.
- `stall`  in  1  hold PC and fetch outputs.
- `redirect`  in  1  replace PC with `redirect_pc`.
- `redirect_pc`  in  ADDR_WIDTH  redirect target byte address.
- `instr`  out  DATA_WIDTH  fetched instruction.
- `instr_pc`  out  ADDR_WIDTH  byte address of `instr`.
- `instr_valid`  out  1  `instr`/`instr_pc` are a live fetch.
- `running`  out  1  state is RUN.
- `fault`  out  1  sticky fault.
- `fault_pc`  out  ADDR_WIDTH  address that caused the fault.

## Operation
- Word index = (addr − `BOOT_ADDR`) >> 2. An address is in range iff addr ≥ `BOOT_ADDR` and index < `DEPTH_WORDS`. It is aligned iff addr[1:0] == 0.
- States: LOAD, RUN, FAULT. Reset enters LOAD.
- LOAD:
  - `load_ready` = 1; a transfer occurs on `load_valid` & `load_ready`.
  - An in-range, aligned transfer writes the whole word at its index. Any other transfer is accepted, discarded, and sets `load_err`.
  - A transfer with `load_last` = 1 moves to RUN on the next edge. Its own write still completes.
  - While in LOAD: `stall` and `redirect` are ignored, `fetch_pc` = `BOOT_ADDR`, `instr_valid` = 0.
- RUN: internal `fetch_pc` addresses the memory. Per cycle, in priority order:
  1. `redirect` = 1 with `redirect_pc` misaligned or out of range: go to FAULT, `fault_pc` ← `redirect_pc`.
  2. `redirect` = 1, target valid: `fetch_pc` ← `redirect_pc`, `instr_valid` ← 0. This squashes the in-flight fetch, even when `stall` = 1.
  3. `stall` = 1: `fetch_pc`, `instr`, `instr_pc` and `instr_valid` all hold.
  4. `fetch_pc` out of range (sequential run-off): go to FAULT, `fault_pc` ← `fetch_pc`.
  5. Otherwise: `instr` ← mem[idx(`fetch_pc`)], `instr_pc` ← `fetch_pc`, `instr_valid` ← 1, `fetch_pc` ← `fetch_pc` + 4 (modulo 2^ADDR_WIDTH).
- FAULT: `fault` = 1 and `instr_valid` = 0. No exit except `rst`. Loads, stall and redirect are ignored.
- In RUN and FAULT: `load_ready` = 0 and the memory is read-only.

## Timing
- Reset values after the `rst` edge:
  - state LOAD, `fetch_pc` = `BOOT_ADDR`.
  - `instr` = 0, `instr_pc` = 0, `instr_valid` = 0.
  - `fault` = 0, `fault_pc` = 0, `load_err` = 0, `running` = 0.
  - Memory contents are not cleared.
- `load_ready` = (state == LOAD); it is high in the first cycle after reset.
- Read latency is 1 cycle. Let cycle R be the first cycle in RUN. Then the cycle R+1 outputs are `instr` = mem[0], `instr_pc` = `BOOT_ADDR`, `instr_valid` = 1. Throughput is 1 instruction per cycle when unstalled.
- A write on the `load_last` edge is visible to the read in cycle R; there is no bypass hazard.
- Redirect asserted in cycle N gives `instr_valid` = 0 in N+1 and the target instruction valid in N+2.
- Stall is asserted combinationally for the cycle it applies to. Outputs are frozen on the following edge.
- `rst` asserted mid-RUN or mid-LOAD overrides everything on that edge. The pending fetch and the pending write are both discarded.
- `fault` and `fault_pc` update on the edge that enters FAULT and then stay constant.

## Test plan
- Load the 4-word add_registers image at 0x0–0xC with `load_last` on word 3, then leave `stall` = 0 → `running` rises one cycle later. Over the next 4 cycles `instr_pc` = 0x0, 0x4, 0x8, 0xC, each with `instr` equal to the image word and `instr_valid` = 1.
- Hold `stall` = 1 for 3 cycles while `instr_pc` = 0x4 → `instr_pc` and `instr` stay frozen for 3 cycles. The output after release is 0x8; no word is skipped or duplicated.
- Apply `redirect` = 1, `redirect_pc` = 0x0 while `instr_pc` = 0x8, with `stall` also 1 → next cycle `instr_valid` = 0, following cycle `instr_pc` = 0x0 valid.
- Apply `redirect_pc` = 0x6 → `fault` = 1 and `fault_pc` = 0x6 on the next edge, `instr_valid` = 0. Both stay sticky until `rst`.
- With `DEPTH_WORDS` = 8, load 8 words and run unstalled → valid outputs for `instr_pc` 0x0 through 0x1C, then `fault` = 1 with `fault_pc` = 0x20.
- Load word to 0x2002 (misaligned) → `load_err` = 1 and no memory change. Then assert `rst` mid-RUN → all outputs return to their reset values, `load_ready` = 1, and the previous image is still fetchable after a new `load_last`.
